// File: rtl/matmul_seq_pkg.sv
// Shared types and defaults for the matmul job sequencer.
// Imported by the sequencer top and its APB engine.
package matmul_seq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      W_SETUP,
      W_ACCESS,
      WAIT_BUSY,
      R_SETUP,
      R_ACCESS,
      R_HOLD,
      DONE
   } state_t;

   localparam logic [15:0] DEF_CTRL_ADDR = 16'h0000;
   localparam int DEF_TIMEOUT = 1024;
   localparam int DEF_MAX_RD = 16;

endpackage

// File: rtl/matmul_sequencer_if.sv
// Job, APB, busy and result signals of the matmul sequencer.
// master = sequencer side, slave = environment side.
interface matmul_sequencer_if #(
   parameter int BUS_WIDTH = 32,
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 16,
   parameter int MAX_RD = 16
);
   localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH;
   localparam int CW = $clog2(MAX_RD + 1);

   logic                  job_valid_i;
   logic                  job_ready_o;
   logic [BUS_WIDTH-1:0]  job_ctrl_i;
   logic [ADDR_WIDTH-1:0] job_rd_base_i;
   logic [CW-1:0]         job_rd_cnt_i;

   logic                  psel_o;
   logic                  penable_o;
   logic                  pwrite_o;
   logic [MAX_DIM-1:0]    pstrb_o;
   logic [BUS_WIDTH-1:0]  pwdata_o;
   logic [ADDR_WIDTH-1:0] paddr_o;
   logic                  pready_i;
   logic                  pslverr_i;
   logic [BUS_WIDTH-1:0]  prdata_i;

   logic                  busy_i;

   logic                  res_valid_o;
   logic                  res_ready_i;
   logic [BUS_WIDTH-1:0]  res_data_o;
   logic                  res_last_o;
   logic                  done_o;
   logic                  err_o;

   modport master (
      input  job_valid_i, job_ctrl_i,
      input  job_rd_base_i, job_rd_cnt_i,
      output job_ready_o,
      output psel_o, penable_o, pwrite_o,
      output pstrb_o, pwdata_o, paddr_o,
      input  pready_i, pslverr_i, prdata_i,
      input  busy_i,
      output res_valid_o, res_data_o,
      output res_last_o,
      input  res_ready_i,
      output done_o, err_o
   );

   modport slave (
      output job_valid_i, job_ctrl_i,
      output job_rd_base_i, job_rd_cnt_i,
      input  job_ready_o,
      input  psel_o, penable_o, pwrite_o,
      input  pstrb_o, pwdata_o, paddr_o,
      output pready_i, pslverr_i, prdata_i,
      output busy_i,
      input  res_valid_o, res_data_o,
      input  res_last_o,
      output res_ready_i,
      input  done_o, err_o
   );

endinterface

// File: rtl/matmul_apb_master.sv
// Single APB transfer engine; the caller sequences SETUP/ACCESS.
// Bus outputs are zero whenever no transfer is in flight.
module matmul_apb_master #(
   parameter int AW = 16,
   parameter int BW = 32,
   parameter int SW = 4
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          setup_i,
   input  logic          access_i,
   input  logic          write_i,
   input  logic [AW-1:0] addr_i,
   input  logic [BW-1:0] wdata_i,
   input  logic [SW-1:0] strb_i,
   input  logic          pready_i,
   input  logic          pslverr_i,
   input  logic [BW-1:0] prdata_i,
   output logic          psel_o,
   output logic          penable_o,
   output logic          pwrite_o,
   output logic [AW-1:0] paddr_o,
   output logic [BW-1:0] pwdata_o,
   output logic [SW-1:0] pstrb_o,
   output logic          done_o,
   output logic          err_o,
   output logic [BW-1:0] rdata_o
);

   logic sel;

   assign sel       = setup_i | access_i;
   assign psel_o    = sel;
   assign penable_o = access_i;
   assign pwrite_o  = sel & write_i;
   assign paddr_o   = sel ? addr_i : '0;
   assign pwdata_o  = sel ? wdata_i : '0;
   assign pstrb_o   = sel ? strb_i : '0;
   assign done_o    = access_i & pready_i;
   assign err_o     = done_o & pslverr_i;

   // Error responses never overwrite the held word.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rdata_o <= '0;
      end else if (done_o && !pslverr_i && !write_i) begin
         rdata_o <= prdata_i;
      end
   end

endmodule

// File: rtl/matmul_sequencer.sv
// Matmul job sequencer: writes the control word over APB, waits
// for busy to drop, then streams the result words out.
module matmul_sequencer
   import matmul_seq_pkg::*;
#(
   parameter int BUS_WIDTH = 32,
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 16,
   parameter logic [ADDR_WIDTH-1:0] CTRL_ADDR =
      ADDR_WIDTH'(DEF_CTRL_ADDR),
   parameter int MAX_RD = DEF_MAX_RD,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input logic clk_i,
   input logic rst_i,
   matmul_sequencer_if.master bus
);

   localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH;
   localparam int CW = $clog2(MAX_RD + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   state_t state_q;
   state_t state_d;

   logic [BUS_WIDTH-1:0]  ctrl_q;
   logic [ADDR_WIDTH-1:0] base_q;
   logic [CW-1:0]         cnt_q;
   logic [CW-1:0]         idx_q;
   logic [TW-1:0]         tmo_q;
   logic                  err_q;
   logic                  abort;
   logic                  last;

   logic                  ap_setup;
   logic                  ap_access;
   logic                  ap_write;
   logic [ADDR_WIDTH-1:0] ap_addr;
   logic [BUS_WIDTH-1:0]  ap_wdata;
   logic [MAX_DIM-1:0]    ap_strb;
   logic                  xfer_done;
   logic                  xfer_err;
   logic [BUS_WIDTH-1:0]  rdata;

   assign last = (idx_q == cnt_q - CW'(1));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      abort   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.job_valid_i) state_d = W_SETUP;
         end
         W_SETUP: state_d = W_ACCESS;
         W_ACCESS: begin
            if (xfer_done) begin
               if (xfer_err) begin
                  state_d = DONE;
                  abort   = 1'b1;
               end else begin
                  state_d = WAIT_BUSY;
               end
            end
         end
         // tmo_q == 0 is the guard cycle: busy may lag the write.
         WAIT_BUSY: begin
            if (tmo_q != '0) begin
               if (!bus.busy_i) begin
                  state_d = (cnt_q == '0) ? DONE : R_SETUP;
               end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                  state_d = DONE;
                  abort   = 1'b1;
               end
            end
         end
         R_SETUP: state_d = R_ACCESS;
         R_ACCESS: begin
            if (xfer_done) begin
               if (xfer_err) begin
                  state_d = DONE;
                  abort   = 1'b1;
               end else begin
                  state_d = R_HOLD;
               end
            end
         end
         R_HOLD: begin
            if (bus.res_ready_i) begin
               state_d = last ? DONE : R_SETUP;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.job_ready_o = (state_q == IDLE) && !rst_i;
      ap_setup  = (state_q == W_SETUP) || (state_q == R_SETUP);
      ap_access = (state_q == W_ACCESS) || (state_q == R_ACCESS);
      ap_write  = (state_q == W_SETUP) || (state_q == W_ACCESS);
      ap_addr   = base_q + ADDR_WIDTH'(idx_q);
      ap_wdata  = '0;
      ap_strb   = '0;
      if (ap_write) begin
         ap_addr  = CTRL_ADDR;
         ap_wdata = ctrl_q;
         ap_strb  = {MAX_DIM{1'b1}};
      end
      bus.res_valid_o = (state_q == R_HOLD);
      bus.res_data_o  = '0;
      bus.res_last_o  = 1'b0;
      if (state_q == R_HOLD) begin
         bus.res_data_o = rdata;
         bus.res_last_o = last;
      end
      bus.done_o = (state_q == DONE);
      bus.err_o  = (state_q == DONE) && err_q;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ctrl_q <= '0;
         base_q <= '0;
         cnt_q  <= '0;
         idx_q  <= '0;
         tmo_q  <= '0;
         err_q  <= 1'b0;
      end else begin
         if (state_q == IDLE && bus.job_valid_i) begin
            ctrl_q <= bus.job_ctrl_i;
            base_q <= bus.job_rd_base_i;
            cnt_q  <= (bus.job_rd_cnt_i > CW'(MAX_RD)) ?
                      CW'(MAX_RD) : bus.job_rd_cnt_i;
            idx_q  <= '0;
            err_q  <= 1'b0;
         end
         if (abort) err_q <= 1'b1;
         if (state_q == R_HOLD && bus.res_ready_i) begin
            idx_q <= idx_q + CW'(1);
         end
         tmo_q <= (state_q == WAIT_BUSY) ? tmo_q + TW'(1) : '0;
      end
   end

   matmul_apb_master #(
      .AW(ADDR_WIDTH),
      .BW(BUS_WIDTH),
      .SW(MAX_DIM)
   ) u_apb (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .setup_i  (ap_setup),
      .access_i (ap_access),
      .write_i  (ap_write),
      .addr_i   (ap_addr),
      .wdata_i  (ap_wdata),
      .strb_i   (ap_strb),
      .pready_i (bus.pready_i),
      .pslverr_i(bus.pslverr_i),
      .prdata_i (bus.prdata_i),
      .psel_o   (bus.psel_o),
      .penable_o(bus.penable_o),
      .pwrite_o (bus.pwrite_o),
      .paddr_o  (bus.paddr_o),
      .pwdata_o (bus.pwdata_o),
      .pstrb_o  (bus.pstrb_o),
      .done_o   (xfer_done),
      .err_o    (xfer_err),
      .rdata_o  (rdata)
   );

endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed bench for matmul_sequencer with an APB slave model,
// a busy generator and a negedge transaction monitor.
module tb_matmul_sequencer;

   localparam int BW = 32;
   localparam int DW = 8;
   localparam int AW = 16;
   localparam int MR = 16;
   localparam int TO = 1024;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   matmul_sequencer_if #(
      .BUS_WIDTH(BW), .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW), .MAX_RD(MR)
   ) bus ();

   matmul_sequencer #(
      .BUS_WIDTH(BW), .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW), .CTRL_ADDR(16'h0000),
      .MAX_RD(MR), .TIMEOUT(TO)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus)
   );

   int   pdly = 0;
   logic err_wr = 1'b0;
   logic err_rd = 1'b0;
   int   busy_len = 0;
   int   wait_cnt = 0;
   int   bcnt = 0;

   assign bus.pready_i = bus.psel_o && bus.penable_o &&
                         (wait_cnt >= pdly);
   assign bus.pslverr_i = bus.pready_i &&
                          (bus.pwrite_o ? err_wr : err_rd);
   assign bus.prdata_i = {16'hBEEF, bus.paddr_o};
   assign bus.busy_i = (bcnt != 0);

   always @(posedge clk) begin
      if (bus.psel_o && bus.penable_o && !bus.pready_i)
         wait_cnt <= wait_cnt + 1;
      else
         wait_cnt <= 0;
      if (bus.psel_o && bus.penable_o && bus.pready_i &&
          bus.pwrite_o)
         bcnt <= busy_len;
      else if (bcnt != 0)
         bcnt <= bcnt - 1;
   end

   int n_wr = 0, n_rd = 0, n_res = 0, n_done = 0, n_last = 0;
   int apb_bad = 0, res_bad = 0, dbl_done = 0;
   logic          last_err = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [BW-1:0] wr_data = '0;
   logic [3:0]    wr_strb = '0;
   logic [AW-1:0] rd_addr [64];
   logic [BW-1:0] res_dat [64];
   logic          res_lst [64];
   logic          p_xfer = 1'b0, p_hold = 1'b0, p_done = 1'b0;
   logic [AW-1:0] pa = '0;
   logic          pw = 1'b0;
   logic [BW-1:0] pd = '0, ph_d = '0;
   logic [3:0]    ps = '0;

   always @(negedge clk) begin
      if (rst) begin
         p_xfer <= 1'b0;
         p_hold <= 1'b0;
         p_done <= 1'b0;
      end else begin
         if (bus.psel_o && bus.penable_o && bus.pready_i) begin
            if (bus.pwrite_o) begin
               wr_addr <= bus.paddr_o;
               wr_data <= bus.pwdata_o;
               wr_strb <= bus.pstrb_o;
               n_wr    <= n_wr + 1;
            end else begin
               rd_addr[n_rd % 64] <= bus.paddr_o;
               n_rd <= n_rd + 1;
            end
         end
         if (bus.res_valid_o && bus.res_ready_i) begin
            res_dat[n_res % 64] <= bus.res_data_o;
            res_lst[n_res % 64] <= bus.res_last_o;
            n_res <= n_res + 1;
            if (bus.res_last_o) n_last <= n_last + 1;
         end
         if (bus.done_o) begin
            n_done   <= n_done + 1;
            last_err <= bus.err_o;
            if (p_done) dbl_done <= dbl_done + 1;
         end
         if (p_xfer && !(bus.psel_o && bus.penable_o &&
             bus.paddr_o == pa && bus.pwrite_o == pw &&
             bus.pwdata_o == pd && bus.pstrb_o == ps))
            apb_bad <= apb_bad + 1;
         p_xfer <= bus.psel_o &&
                   !(bus.penable_o && bus.pready_i);
         pa <= bus.paddr_o;
         pw <= bus.pwrite_o;
         pd <= bus.pwdata_o;
         ps <= bus.pstrb_o;
         if (p_hold && !(bus.res_valid_o &&
             bus.res_data_o == ph_d))
            res_bad <= res_bad + 1;
         p_hold <= bus.res_valid_o && !bus.res_ready_i;
         ph_d   <= bus.res_data_o;
         p_done <= bus.done_o;
      end
   end

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag,
                        input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic start_job(input logic [31:0] c,
                            input logic [15:0] b,
                            input logic [4:0]  n);
      @(posedge clk); #1;
      bus.job_valid_i   = 1'b1;
      bus.job_ctrl_i    = c;
      bus.job_rd_base_i = b;
      bus.job_rd_cnt_i  = n;
      @(negedge clk);
      check("ready_idle", 64'(bus.job_ready_o), 64'd1);
      @(posedge clk); #1;
      bus.job_valid_i = 1'b0;
      @(negedge clk);
      check("ready_busy", 64'(bus.job_ready_o), 64'd0);
   endtask

   task automatic wait_done(input int budget, output int cyc);
      int d0;
      d0  = n_done;
      cyc = 0;
      while (n_done == d0 && cyc < budget) begin
         @(negedge clk);
         cyc++;
      end
      if (n_done == d0) check("done_seen", 64'd0, 64'd1);
   endtask

   int w0, r0, s0, l0, d0, cyc, k;

   initial begin
      rst = 1'b1;
      bus.job_valid_i   = 1'b0;
      bus.job_ctrl_i    = '0;
      bus.job_rd_base_i = '0;
      bus.job_rd_cnt_i  = '0;
      bus.res_ready_i   = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_ready", 64'(bus.job_ready_o), 64'd0);
      check("rst_psel", 64'(bus.psel_o), 64'd0);
      check("rst_done", 64'(bus.done_o), 64'd0);
      check("rst_valid", 64'(bus.res_valid_o), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("idle_ready", 64'(bus.job_ready_o), 64'd1);

      // basic two-word job
      busy_len = 5;
      w0 = n_wr; r0 = n_rd; s0 = n_res; l0 = n_last;
      start_job(32'h1, 16'h0100, 5'd2);
      wait_done(200, cyc);
      check("t1_nwr", 64'(n_wr - w0), 64'd1);
      check("t1_waddr", 64'(wr_addr), 64'h0000);
      check("t1_wdata", 64'(wr_data), 64'h1);
      check("t1_wstrb", 64'(wr_strb), 64'hF);
      check("t1_nrd", 64'(n_rd - r0), 64'd2);
      check("t1_raddr0", 64'(rd_addr[r0 % 64]), 64'h0100);
      check("t1_raddr1", 64'(rd_addr[(r0+1) % 64]), 64'h0101);
      check("t1_nres", 64'(n_res - s0), 64'd2);
      check("t1_dat0", 64'(res_dat[s0 % 64]), 64'hBEEF0100);
      check("t1_dat1", 64'(res_dat[(s0+1) % 64]), 64'hBEEF0101);
      check("t1_last0", 64'(res_lst[s0 % 64]), 64'd0);
      check("t1_last1", 64'(res_lst[(s0+1) % 64]), 64'd1);
      check("t1_err", 64'(last_err), 64'd0);

      // zero-count job
      busy_len = 3;
      w0 = n_wr; r0 = n_rd; s0 = n_res;
      start_job(32'h2, 16'h0300, 5'd0);
      wait_done(200, cyc);
      check("t2_nwr", 64'(n_wr - w0), 64'd1);
      check("t2_wdata", 64'(wr_data), 64'h2);
      check("t2_nrd", 64'(n_rd - r0), 64'd0);
      check("t2_nres", 64'(n_res - s0), 64'd0);
      check("t2_err", 64'(last_err), 64'd0);

      // slave error on control write
      err_wr = 1'b1;
      r0 = n_rd; s0 = n_res;
      start_job(32'h3, 16'h0400, 5'd2);
      wait_done(200, cyc);
      err_wr = 1'b0;
      check("t3_err", 64'(last_err), 64'd1);
      check("t3_nrd", 64'(n_rd - r0), 64'd0);
      check("t3_nres", 64'(n_res - s0), 64'd0);

      // busy never drops
      busy_len = 2000;
      r0 = n_rd;
      start_job(32'h4, 16'h0500, 5'd1);
      wait_done(3000, cyc);
      check("t4_err", 64'(last_err), 64'd1);
      check("t4_nrd", 64'(n_rd - r0), 64'd0);
      check("t4_cyc", 64'(cyc >= TO && cyc <= TO + 8), 64'd1);

      // backpressure, slow slave, address wrap
      busy_len = 4;
      pdly = 3;
      bus.res_ready_i = 1'b0;
      r0 = n_rd; s0 = n_res; l0 = n_last;
      start_job(32'h5, 16'hFFFF, 5'd2);
      k = 0;
      while (!bus.res_valid_o && k < 200) begin
         @(negedge clk);
         k++;
      end
      check("t5_valid", 64'(bus.res_valid_o), 64'd1);
      repeat (10) @(negedge clk);
      check("t5_hold_v", 64'(bus.res_valid_o), 64'd1);
      check("t5_hold_d", 64'(bus.res_data_o), 64'hBEEFFFFF);
      check("t5_hold_sel", 64'(bus.psel_o), 64'd0);
      @(posedge clk); #1;
      bus.res_ready_i = 1'b1;
      wait_done(200, cyc);
      check("t5_nrd", 64'(n_rd - r0), 64'd2);
      check("t5_raddr0", 64'(rd_addr[r0 % 64]), 64'hFFFF);
      check("t5_raddr1", 64'(rd_addr[(r0+1) % 64]), 64'h0000);
      check("t5_dat1", 64'(res_dat[(s0+1) % 64]), 64'hBEEF0000);
      check("t5_nlast", 64'(n_last - l0), 64'd1);
      check("t5_apb_stable", 64'(apb_bad), 64'd0);
      check("t5_res_stable", 64'(res_bad), 64'd0);
      check("t5_err", 64'(last_err), 64'd0);

      // reset in the middle of a read access
      busy_len = 2;
      pdly = 5;
      d0 = n_done;
      start_job(32'h6, 16'h0600, 5'd1);
      k = 0;
      while (!(bus.psel_o && bus.penable_o && !bus.pwrite_o) &&
             k < 200) begin
         @(negedge clk);
         k++;
      end
      check("t6_in_read", 64'(bus.psel_o && !bus.pwrite_o),
            64'd1);
      #1 rst = 1'b1;
      #1;
      check("t6_psel", 64'(bus.psel_o), 64'd0);
      check("t6_pen", 64'(bus.penable_o), 64'd0);
      check("t6_paddr", 64'(bus.paddr_o), 64'd0);
      check("t6_ready", 64'(bus.job_ready_o), 64'd0);
      check("t6_done", 64'(bus.done_o), 64'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      pdly = 0;
      repeat (3) @(negedge clk);
      check("t6_no_done", 64'(n_done - d0), 64'd0);
      check("t6_idle", 64'(bus.job_ready_o), 64'd1);

      // oversize count is clamped
      busy_len = 1;
      r0 = n_rd; s0 = n_res; l0 = n_last;
      start_job(32'h7, 16'h0200, 5'd20);
      wait_done(500, cyc);
      check("t7_nrd", 64'(n_rd - r0), 64'd16);
      check("t7_raddr15", 64'(rd_addr[(r0+15) % 64]), 64'h020F);
      check("t7_nres", 64'(n_res - s0), 64'd16);
      check("t7_last15", 64'(res_lst[(s0+15) % 64]), 64'd1);
      check("t7_nlast", 64'(n_last - l0), 64'd1);
      check("t7_err", 64'(last_err), 64'd0);
      check("done_pulse", 64'(dbl_done), 64'd0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
